// File: rtl/rand_gen_pkg.sv
// Shared types and constants for the bounded pseudo-random source.
package rand_gen_pkg;

  typedef enum logic [0:0] {
    IDLE,
    DRAW
  } rand_gen_state_e;

  // x^21 + x^19 + 1
  localparam logic [20:0] DEFAULT_TAPS_21 = 21'h140000;

endpackage

// File: rtl/lfsr_core.sv
// Fibonacci LFSR with runtime seeding and all-zero lockup recovery.
module lfsr_core #(
  parameter int unsigned      WIDTH = 21,
  parameter logic [WIDTH-1:0] TAPS  = 21'h140000,
  parameter logic [WIDTH-1:0] SEED  = '1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             step,
  input  logic             seed_load,
  input  logic [WIDTH-1:0] seed_in,
  output logic [WIDTH-1:0] state
);

  logic [WIDTH-1:0] state_q, state_d;

  always_comb begin
    state_d = state_q;
    if (seed_load) begin
      // A zero seed would lock the register, so substitute the reset seed.
      state_d = (seed_in == '0) ? SEED : seed_in;
    end else if (step) begin
      state_d = (state_q == '0) ? SEED : {state_q[WIDTH-2:0], ^(state_q & TAPS)};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= SEED;
    end else begin
      state_q <= state_d;
    end
  end

  assign state = state_q;

endmodule

// File: rtl/rand_range_gen.sv
// Request/valid wrapper returning LFSR values bounded to [MIN, MAX] by rejection sampling,
// clamping to the nearer bound after MAX_TRIES draw cycles.
module rand_range_gen
  import rand_gen_pkg::*;
#(
  parameter int unsigned      WIDTH     = 21,
  parameter logic [WIDTH-1:0] TAPS      = DEFAULT_TAPS_21,
  parameter logic [WIDTH-1:0] SEED      = '1,
  parameter int unsigned      OUT_W     = 7,
  parameter int unsigned      MIN       = 10,
  parameter int unsigned      MAX       = 90,
  parameter int unsigned      MAX_TRIES = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             seed_load,
  input  logic [WIDTH-1:0] seed_in,
  input  logic             req,
  output logic             ready,
  output logic             out_valid,
  output logic [OUT_W-1:0] out
);

  localparam int unsigned       TriesW  = $clog2(MAX_TRIES + 1);
  localparam logic [OUT_W-1:0]  MinVal  = OUT_W'(MIN);
  localparam logic [OUT_W-1:0]  MaxVal  = OUT_W'(MAX);
  localparam logic [TriesW-1:0] LastTry = TriesW'(MAX_TRIES - 1);

  rand_gen_state_e   fsm_q;
  logic [TriesW-1:0] tries_q;
  logic              out_valid_q;
  logic [OUT_W-1:0]  out_q;

  logic [WIDTH-1:0]  state;
  logic [OUT_W-1:0]  cand;
  logic              in_range;
  logic              last_try;
  logic              step;
  logic              unused_state;

  // The LFSR advances on every DRAW cycle regardless of en.
  assign step = (fsm_q == IDLE) ? (en | req) : 1'b1;

  lfsr_core #(
    .WIDTH (WIDTH),
    .TAPS  (TAPS),
    .SEED  (SEED)
  ) u_lfsr (
    .clk       (clk),
    .reset     (reset),
    .step      (step),
    .seed_load (seed_load),
    .seed_in   (seed_in),
    .state     (state)
  );

  assign cand         = state[OUT_W-1:0];
  assign unused_state = ^state;
  assign in_range     = (cand >= MinVal) && (cand <= MaxVal);
  assign last_try     = (tries_q == LastTry);

  always_ff @(posedge clk) begin
    if (reset) begin
      fsm_q       <= IDLE;
      tries_q     <= '0;
      out_valid_q <= 1'b0;
      out_q       <= '0;
    end else begin
      out_valid_q <= 1'b0;
      unique case (fsm_q)
        IDLE: begin
          if (req) begin
            fsm_q   <= DRAW;
            tries_q <= '0;
          end
        end
        DRAW: begin
          if (in_range) begin
            out_q       <= cand;
            out_valid_q <= 1'b1;
            fsm_q       <= IDLE;
          end else if (last_try) begin
            out_q       <= (cand < MinVal) ? MinVal : MaxVal;
            out_valid_q <= 1'b1;
            fsm_q       <= IDLE;
          end else begin
            tries_q <= tries_q + 1'b1;
          end
        end
        default: fsm_q <= IDLE;
      endcase
    end
  end

  assign ready     = (fsm_q == IDLE);
  assign out_valid = out_valid_q;
  assign out       = out_q;

endmodule
